// File: rtl/trng_pkg.sv
// Shared types and helpers for the TRNG byte collector and its output FIFO.
package trng_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    FAULT
  } state_e;

  localparam int BYTE_W = 8;

  // Pointer carries one extra wrap bit so full and empty can be told apart.
  function automatic int ptrWidth(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/trng_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with flush, fill count and sync active-low reset.
module trng_sync_fifo
  import trng_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = BYTE_W
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [WIDTH-1:0]       i_data,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_fill
);

  localparam int PW = ptrWidth(DEPTH);
  localparam int AW = PW - 1;

  logic [PW-1:0]    wrPtr_q, wrPtr_d;
  logic [PW-1:0]    rdPtr_q, rdPtr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             doPush;
  logic             doPop;

  assign o_empty = (wrPtr_q == rdPtr_q);
  assign o_full  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign o_fill  = wrPtr_q - rdPtr_q;
  assign o_data  = mem_q[rdPtr_q[AW-1:0]];

  // A full FIFO still accepts a push when the head is popped in the same edge.
  assign doPop  = i_pop && !o_empty;
  assign doPush = i_push && (!o_full || doPop);

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    if (i_flush) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
    end else begin
      if (doPush) wrPtr_d = wrPtr_q + PW'(1);
      if (doPop)  rdPtr_d = rdPtr_q + PW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      if (doPush && !i_flush) mem_q[wrPtr_q[AW-1:0]] <= i_data;
    end
  end

endmodule

// File: rtl/trng_byte_collector.sv
// Packs debiased TRNG bits MSB-first into bytes, runs a repetition-count health
// test on the stream and buffers completed bytes in a small FWFT FIFO.
module trng_byte_collector
  import trng_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int REP_LIMIT  = 16
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_en,
  input  logic                        i_random,
  input  logic                        i_valid,
  input  logic                        i_rd,
  input  logic                        i_clr,
  output logic [BYTE_W-1:0]           o_data,
  output logic                        o_data_valid,
  output logic [$clog2(FIFO_DEPTH):0] o_fill,
  output logic                        o_overflow,
  output logic                        o_health_fail
);

  localparam int RW = $clog2(REP_LIMIT + 1);

  state_e            state_q, state_d;
  logic [BYTE_W-2:0] shreg_q, shreg_d;
  logic [2:0]        bitCnt_q, bitCnt_d;
  logic [RW-1:0]     runCnt_q, runCnt_d;
  logic              lastBit_q, lastBit_d;
  logic              overflow_q, overflow_d;
  logic              healthFail_q, healthFail_d;

  logic [RW-1:0]     runNext;
  logic [BYTE_W-1:0] pushData;
  logic              accept, trip, push, pop;
  logic              fifoFull, fifoEmpty;

  // A run count of zero marks "no previous bit", so the next accepted bit restarts at 1.
  assign accept   = (state_q == COLLECT) && i_en && i_valid;
  assign runNext  = ((runCnt_q != '0) && (i_random == lastBit_q)) ? runCnt_q + RW'(1) : RW'(1);
  assign trip     = accept && (runNext == RW'(REP_LIMIT));
  assign push     = accept && !trip && (bitCnt_q == 3'd7) && !i_clr;
  assign pushData = {shreg_q, i_random};

  assign o_data_valid  = !fifoEmpty && (state_q != FAULT);
  assign pop           = i_rd && o_data_valid && !i_clr;
  assign o_overflow    = overflow_q;
  assign o_health_fail = healthFail_q;

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bitCnt_d     = bitCnt_q;
    runCnt_d     = runCnt_q;
    lastBit_d    = lastBit_q;
    overflow_d   = overflow_q;
    healthFail_d = healthFail_q;
    if (i_clr) begin
      state_d      = i_en ? COLLECT : IDLE;
      shreg_d      = '0;
      bitCnt_d     = '0;
      runCnt_d     = '0;
      lastBit_d    = 1'b0;
      overflow_d   = 1'b0;
      healthFail_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (i_en) state_d = COLLECT;
        end
        COLLECT: begin
          if (!i_en || trip) begin
            state_d  = i_en ? FAULT : IDLE;
            shreg_d  = '0;
            bitCnt_d = '0;
            runCnt_d = '0;
            if (i_en) healthFail_d = 1'b1;
          end else if (accept) begin
            shreg_d   = {shreg_q[BYTE_W-3:0], i_random};
            bitCnt_d  = bitCnt_q + 3'd1;
            runCnt_d  = runNext;
            lastBit_d = i_random;
            if (push && fifoFull && !pop) overflow_d = 1'b1;
          end
        end
        FAULT: begin
          state_d = FAULT;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      bitCnt_q     <= '0;
      runCnt_q     <= '0;
      lastBit_q    <= 1'b0;
      overflow_q   <= 1'b0;
      healthFail_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bitCnt_q     <= bitCnt_d;
      runCnt_q     <= runCnt_d;
      lastBit_q    <= lastBit_d;
      overflow_q   <= overflow_d;
      healthFail_q <= healthFail_d;
    end
  end

  trng_sync_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(BYTE_W)
  ) u_fifo (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_flush(i_clr),
    .i_push (push),
    .i_pop  (pop),
    .i_data (pushData),
    .o_data (o_data),
    .o_full (fifoFull),
    .o_empty(fifoEmpty),
    .o_fill (o_fill)
  );

endmodule

// File: tb/tb_trng_byte_collector.sv
// Directed scoreboard bench for trng_byte_collector: expected bytes are queued as
// they are sent and checked by a monitor whenever a pop is taken.
module tb_trng_byte_collector;

  localparam int FIFO_DEPTH = 4;
  localparam int REP_LIMIT  = 16;

  logic       clk = 1'b0;
  logic       rstN;
  logic       en;
  logic       randBit;
  logic       valid;
  logic       rd;
  logic       clr;
  logic [7:0] data;
  logic       dataValid;
  logic [2:0] fill;
  logic       overflow;
  logic       healthFail;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] expQ[$];

  always #5 clk = ~clk;

  trng_byte_collector #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .REP_LIMIT (REP_LIMIT)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rstN),
    .i_en         (en),
    .i_random     (randBit),
    .i_valid      (valid),
    .i_rd         (rd),
    .i_clr        (clr),
    .o_data       (data),
    .o_data_valid (dataValid),
    .o_fill       (fill),
    .o_overflow   (overflow),
    .o_health_fail(healthFail)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Monitor: every pop the DUT will honour at the next edge is checked against the scoreboard.
  always @(negedge clk) begin
    if (rstN && rd && dataValid) begin
      if (expQ.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL popData: got %0h, expected no data", data);
      end else begin
        checkOutput("popData", 32'(data), 32'(expQ.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic enV, input logic validV, input logic bitV,
                               input logic rdV, input logic clrV);
    en      = enV;
    valid   = validV;
    randBit = bitV;
    rd      = rdV;
    clr     = clrV;
    tick();
    valid = 1'b0;
    rd    = 1'b0;
    clr   = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b, input logic popOnLast);
    for (int i = 7; i >= 0; i--) begin
      en      = 1'b1;
      valid   = 1'b1;
      randBit = b[i];
      rd      = (i == 0) && popOnLast;
      tick();
    end
    valid = 1'b0;
    rd    = 1'b0;
  endtask

  task automatic popOne(input logic enV);
    applyStimulus(enV, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    logic [7:0] burst [5];
    logic [7:0] fillSet [4];
    burst   = '{8'h55, 8'hAA, 8'h55, 8'hAA, 8'h55};
    fillSet = '{8'h11, 8'h22, 8'h33, 8'h44};

    rstN = 1'b0; en = 1'b0; randBit = 1'b0; valid = 1'b0; rd = 1'b0; clr = 1'b0;
    tick();
    tick();
    rstN = 1'b1;
    checkOutput("resetData", 32'(data), 32'h0);
    checkOutput("resetValid", 32'(dataValid), 32'h0);
    checkOutput("resetFill", 32'(fill), 32'h0);
    checkOutput("resetOverflow", 32'(overflow), 32'h0);
    checkOutput("resetHealth", 32'(healthFail), 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Basic packing: 1,0,1,1,0,0,1,0 -> B2
    expQ.push_back(8'hB2);
    sendByte(8'hB2, 1'b0);
    checkOutput("packData", 32'(data), 32'hB2);
    checkOutput("packValid", 32'(dataValid), 32'h1);
    checkOutput("packFill", 32'(fill), 32'h1);
    popOne(1'b1);
    checkOutput("drainFill", 32'(fill), 32'h0);
    checkOutput("drainValid", 32'(dataValid), 32'h0);

    // Overflow: fifth byte dropped when full
    for (int i = 0; i < 5; i++) begin
      if (i < 4) expQ.push_back(burst[i]);
      sendByte(burst[i], 1'b0);
    end
    checkOutput("ovfFill", 32'(fill), 32'h4);
    checkOutput("ovfFlag", 32'(overflow), 32'h1);
    checkOutput("ovfHead", 32'(data), 32'h55);
    for (int i = 0; i < 4; i++) popOne(1'b1);
    checkOutput("ovfSticky", 32'(overflow), 32'h1);
    checkOutput("ovfDrained", 32'(fill), 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("ovfCleared", 32'(overflow), 32'h0);

    // Full FIFO with push and pop on the same edge
    for (int i = 0; i < 4; i++) begin
      expQ.push_back(fillSet[i]);
      sendByte(fillSet[i], 1'b0);
    end
    expQ.push_back(8'hC7);
    sendByte(8'hC7, 1'b1);
    checkOutput("pushPopFill", 32'(fill), 32'h4);
    checkOutput("pushPopOverflow", 32'(overflow), 32'h0);
    for (int i = 0; i < 4; i++) popOne(1'b1);
    checkOutput("pushPopDrained", 32'(fill), 32'h0);

    // Health test: 16 ones trips at the 16th bit
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("healthBelowLimit", 32'(healthFail), 32'h0);
    checkOutput("healthFirstByte", 32'(fill), 32'h1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("healthTrip", 32'(healthFail), 32'h1);
    checkOutput("healthGatedValid", 32'(dataValid), 32'h0);
    checkOutput("healthNoPush", 32'(fill), 32'h1);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    popOne(1'b1);
    checkOutput("faultIgnores", 32'(fill), 32'h1);
    checkOutput("faultHeld", 32'(healthFail), 32'h1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("clrHealth", 32'(healthFail), 32'h0);
    checkOutput("clrOverflow", 32'(overflow), 32'h0);
    checkOutput("clrFill", 32'(fill), 32'h0);
    expQ.push_back(8'h69);
    sendByte(8'h69, 1'b0);
    checkOutput("afterClrData", 32'(data), 32'h69);
    popOne(1'b1);

    // Reset mid-word discards the partial byte
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    rstN = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    rstN = 1'b1;
    checkOutput("midResetData", 32'(data), 32'h0);
    checkOutput("midResetValid", 32'(dataValid), 32'h0);
    checkOutput("midResetFill", 32'(fill), 32'h0);
    checkOutput("midResetFlags", 32'({overflow, healthFail}), 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    expQ.push_back(8'h3C);
    sendByte(8'h3C, 1'b0);
    checkOutput("freshByte", 32'(data), 32'h3C);
    popOne(1'b1);

    // Disable mid-word: partial dropped, earlier FIFO data still readable
    expQ.push_back(8'h96);
    sendByte(8'h96, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("idleNoPush", 32'(fill), 32'h1);
    checkOutput("idleReadable", 32'(dataValid), 32'h1);
    popOne(1'b0);
    checkOutput("idleDrained", 32'(fill), 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    expQ.push_back(8'h5A);
    sendByte(8'h5A, 1'b0);
    checkOutput("reEnableData", 32'(data), 32'h5A);
    checkOutput("reEnableFill", 32'(fill), 32'h1);
    popOne(1'b1);

    checkOutput("queueDrained", 32'(expQ.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
